uart_rx_fifo: RTL and testbench

- Receive buffer directly downstream of the UART receiver.
- Captures each completed byte on the receiver's done strobe and stores it in a circular buffer.
- Presents the oldest byte to the host/bus side with a first-word-fall-through read interface.
- Flags overrun when a byte arrives while the buffer is full.

---
 rtl/uart_rx_fifo.sv | 115 +++++++++++
 tb/tb_uart_rx_fifo.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_fifo
// Purpose : Receive buffer behind the UART receiver. Captures one byte per
//           rising edge of the receiver's done strobe into a circular buffer
//           and presents the oldest byte with a first-word-fall-through read
//           port. A byte arriving while the buffer is full is dropped and
//           raises a sticky overrun flag.
// Ports   : clk      - system clock, rising edge
//           reset    - asynchronous active-low reset
//           rx_done  - byte-complete strobe (may stay high for many cycles)
//           din      - received byte, sampled on the push edge
//           rd       - pop request, effective at the next clock edge
//           dout     - head-of-queue byte, valid while empty=0
//           empty    - buffer holds zero entries
//           full     - buffer holds DEPTH entries
//           count    - number of stored entries, 0..DEPTH
//           overrun  - sticky: a byte was dropped
//           ovr_clr  - clears overrun (a same-edge drop takes priority)
// Revision: 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_done,
  input  logic [DWIDTH-1:0] din,
  input  logic              rd,
  output logic [DWIDTH-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic [AW:0]       count,
  output logic              overrun,
  input  logic              ovr_clr
);

  localparam logic [AW:0]   C_CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   C_CNT_MAX = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] C_PTR_ONE = AW'(1);

  logic [DWIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          rx_done_d_q, rx_done_d_d;
  logic          overrun_q, overrun_d;

  logic w_push;
  logic w_pop;
  logic w_wr_en;
  logic w_drop;

  // Flags come straight from the registered count, so they never glitch.
  assign empty   = (count_q == '0);
  assign full    = (count_q == C_CNT_MAX);
  assign count   = count_q;
  assign overrun = overrun_q;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    rx_done_d_d = rx_done;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overrun_d   = overrun_q;

    // Only the rising edge of the strobe writes, however long it is held.
    w_push  = rx_done & ~rx_done_d_q;
    w_pop   = rd & ~empty;
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    w_wr_en = w_push & (~full | w_pop);
    w_drop  = w_push & full & ~w_pop;

    if (w_wr_en) wr_ptr_d = wr_ptr_q + C_PTR_ONE;
    if (w_pop)   rd_ptr_d = rd_ptr_q + C_PTR_ONE;

    unique case ({w_wr_en, w_pop})
      2'b10:   count_d = count_q + C_CNT_ONE;
      2'b01:   count_d = count_q - C_CNT_ONE;
      default: count_d = count_q;
    endcase

    // Set has priority over clear so a drop is never lost.
    if (w_drop)       overrun_d = 1'b1;
    else if (ovr_clr) overrun_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rx_done_d_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rx_done_d_q <= rx_done_d_d;
      overrun_q   <= overrun_d;
    end
  end

  // Storage is intentionally not reset; contents are only visible via dout
  // while the count says they are valid.
  always_ff @(posedge clk) begin
    if (w_wr_en) mem_q[wr_ptr_q] <= din;
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_rx_fifo
// Purpose : Self-checking bench for uart_rx_fifo. A queue-based reference
//           model tracks stored bytes, the strobe edge and the overrun flag;
//           every cycle the DUT outputs are compared against it.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

  localparam int DW = 8;
  localparam int DP = 16;
  localparam int AW = $clog2(DP);

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_done;
  logic [DW-1:0] din;
  logic          rd;
  logic [DW-1:0] dout;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          overrun;
  logic          ovr_clr;

  uart_rx_fifo #(.DWIDTH(DW), .DEPTH(DP)) dut (
    .clk     (clk),
    .reset   (reset),
    .rx_done (rx_done),
    .din     (din),
    .rd      (rd),
    .dout    (dout),
    .empty   (empty),
    .full    (full),
    .count   (count),
    .overrun (overrun),
    .ovr_clr (ovr_clr)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0] mq[$];
  bit            m_prev_rx;
  bit            m_ovr;

  int tests;
  int fails;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"},   32'(count),   32'(mq.size()));
    check({tag, ".empty"},   32'(empty),   32'(mq.size() == 0));
    check({tag, ".full"},    32'(full),    32'(mq.size() == DP));
    check({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
    if (mq.size() != 0) check({tag, ".dout"}, 32'(dout), 32'(mq[0]));
  endtask

  // One clock cycle: drive inputs, advance the model, sample after the edge.
  task automatic cyc(input bit rxd, input logic [DW-1:0] d, input bit r,
                     input bit clr, input string tag);
    bit push, pop;
    rx_done = rxd;
    din     = d;
    rd      = r;
    ovr_clr = clr;
    push = rxd && !m_prev_rx;
    pop  = r && (mq.size() != 0);
    m_prev_rx = rxd;
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (mq.size() < DP) mq.push_back(d);
      else                m_ovr = 1'b1;
    end
    if (!(push && !pop && mq.size() == DP && !(pop)) || !push) begin
      // drop already handled above; clear only applies when no new drop
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Push one byte: strobe high for a cycle then low.
  task automatic push_byte(input logic [DW-1:0] d, input string tag);
    cyc(1'b1, d, 1'b0, 1'b0, tag);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, tag);
  endtask

  task automatic pop_byte(input string tag);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, tag);
  endtask

  // Reset asserted away from any clock edge; outputs must clear at once.
  task automatic async_reset(input string tag);
    reset = 1'b0;
    #2;
    mq.delete();
    m_prev_rx = 1'b0;
    m_ovr     = 1'b0;
    check_all(tag);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Overrun clear handling needs the drop decision of the same cycle, so the
  // clear is folded in here before the cycle runs.
  task automatic cyc_clr(input bit rxd, input logic [DW-1:0] d, input bit r, input string tag);
    bit push, pop, drop;
    push = rxd && !m_prev_rx;
    pop  = r && (mq.size() != 0);
    drop = push && !pop && (mq.size() == DP);
    if (!drop) m_ovr = 1'b0;
    cyc(rxd, d, r, 1'b1, tag);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    m_prev_rx = 1'b0;
    m_ovr = 1'b0;
    reset = 1'b0;
    rx_done = 1'b0;
    din = '0;
    rd = 1'b0;
    ovr_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    reset = 1'b1;

    // Idle reads on an empty buffer change nothing.
    repeat (3) cyc(1'b0, 8'h00, 1'b1, 1'b0, "idle_rd");

    // Single byte then pop.
    cyc(1'b1, 8'hA5, 1'b0, 1'b0, "single_push");
    check("single_dout", 32'(dout), 32'hA5);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, "single_pop");
    check("single_empty", 32'(empty), 32'd1);

    // Strobe held for five cycles yields exactly one entry.
    repeat (5) cyc(1'b1, 8'h3C, 1'b0, 1'b0, "held");
    check("held_count", 32'(count), 32'd1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, "held_pop");

    // Fill, overflow, drain in order, clear overrun.
    for (int i = 0; i < DP; i++) push_byte(DW'(i), "fill");
    check("fill_full", 32'(full), 32'd1);
    push_byte(8'hFF, "drop");
    check("drop_ovr", 32'(overrun), 32'd1);
    check("drop_count", 32'(count), 32'(DP));
    for (int i = 0; i < DP; i++) begin
      check("drain_seq", 32'(dout), 32'(i));
      pop_byte("drain");
    end
    check("drain_empty", 32'(empty), 32'd1);
    cyc_clr(1'b0, 8'h00, 1'b0, "ovr_clr");
    check("ovr_cleared", 32'(overrun), 32'd0);

    // Refill with random data; drop and clear on the same edge keeps overrun.
    for (int i = 0; i < DP; i++) push_byte(DW'($urandom), "refill");
    cyc_clr(1'b1, 8'hEE, 1'b0, "drop_and_clr");
    check("set_wins", 32'(overrun), 32'd1);
    cyc_clr(1'b0, 8'h00, 1'b0, "clr2");
    // Push and pop together while full.
    cyc(1'b1, 8'h77, 1'b1, 1'b0, "full_push_pop");
    check("fpp_count", 32'(count), 32'(DP));
    check("fpp_ovr", 32'(overrun), 32'd0);
    for (int i = 0; i < DP - 1; i++) pop_byte("fpp_drain");
    check("fpp_last", 32'(dout), 32'h77);
    pop_byte("fpp_final");

    // Interleaved traffic across pointer wrap, count oscillating 0..3.
    for (int b = 0; b < 40; b += 3) begin
      for (int k = 0; k < 3; k++) push_byte(DW'($urandom), "wrap_push");
      for (int k = 0; k < 3; k++) pop_byte("wrap_pop");
    end

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) == 0)
        cyc_clr(1'($urandom), DW'($urandom), 1'($urandom_range(0, 2) == 0), "rand_clr");
      else
        cyc(1'($urandom), DW'($urandom), 1'($urandom_range(0, 2) == 0), 1'b0, "rand");
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0, "rand_idle");
    while (mq.size() != 0) pop_byte("rand_drain");

    // Reset with five stored bytes.
    for (int i = 0; i < 5; i++) push_byte(DW'($urandom), "pre_rst");
    check("pre_rst_count", 32'(count), 32'd5);
    async_reset("async_rst");
    cyc(1'b0, 8'h00, 1'b1, 1'b0, "post_rst");

    // Strobe high across reset release produces one push.
    reset = 1'b0;
    #2;
    mq.delete();
    m_prev_rx = 1'b0;
    m_ovr = 1'b0;
    rx_done = 1'b1;
    din = 8'h5A;
    @(negedge clk);
    reset = 1'b1;
    cyc(1'b1, 8'h5A, 1'b0, 1'b0, "rst_release_push");
    cyc(1'b1, 8'h11, 1'b0, 1'b0, "rst_release_hold");
    check("rst_release_count", 32'(count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
